// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds,
// overflow/underflow pulses and a selectable registered or first-word-fall-through read port.
module sync_fifo_param #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int AFULL_THR  = DEPTH - 1,
  parameter int AEMPTY_THR = 1,
  parameter int FWFT       = 0,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_val,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C   = CW'(AFULL_THR);
  localparam logic [CW-1:0] AEMPTY_C  = CW'(AEMPTY_THR);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ready_q, almost_full_q, almost_empty_q;
  logic             overflow_q, underflow_q;
  logic             full, empty, wr_acc, rd_acc;

  // Full/empty come from the count so a non-power-of-two depth needs no extra pointer bit.
  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      wr_ready_q     <= 1'b1;
      almost_full_q  <= (AFULL_THR <= 0);
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      wr_ready_q     <= (count_d != FULL_CNT);
      almost_full_q  <= (count_d >= AFULL_C);
      almost_empty_q <= (count_d <= AEMPTY_C);
      overflow_q     <= wr_en && full;
      underflow_q    <= rd_en && empty;
    end
  end

  // NOTE: the storage array has no reset; clearing the pointers and count is enough to discard it.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data = mem_q[rd_ptr_q];
      assign rd_val  = !empty;
    end else begin : g_reg
      logic [WIDTH-1:0] rd_data_q;
      logic             rd_val_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_data_q <= '0;
          rd_val_q  <= 1'b0;
        end else begin
          rd_val_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
        end
      end

      assign rd_data = rd_data_q;
      assign rd_val  = rd_val_q;
    end
  endgenerate

  assign wr_ready     = wr_ready_q;
  assign count        = count_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: three instances (registered depth 4, registered depth 3,
// FWFT depth 4) checked against per-instance expected-data queues.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Instance A: WIDTH 8, DEPTH 4, registered read
  logic       a_wr_en, a_rd_en, a_wr_ready, a_rd_val, a_af, a_ae, a_ov, a_un;
  logic [7:0] a_wr_data, a_rd_data;
  logic [2:0] a_count;
  // Instance B: DEPTH 3, registered read
  logic       b_wr_en, b_rd_en, b_wr_ready, b_rd_val, b_af, b_ae, b_ov, b_un;
  logic [7:0] b_wr_data, b_rd_data;
  logic [1:0] b_count;
  // Instance C: DEPTH 4, first-word-fall-through
  logic       c_wr_en, c_rd_en, c_wr_ready, c_rd_val, c_af, c_ae, c_ov, c_un;
  logic [7:0] c_wr_data, c_rd_data;
  logic [2:0] c_count;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];
  logic [7:0] exp_d;

  sync_fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_a (
    .clk(clk), .reset(reset), .wr_en(a_wr_en), .wr_data(a_wr_data), .wr_ready(a_wr_ready),
    .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_val(a_rd_val), .count(a_count),
    .almost_full(a_af), .almost_empty(a_ae), .overflow(a_ov), .underflow(a_un));

  sync_fifo_param #(.WIDTH(8), .DEPTH(3), .FWFT(0)) u_b (
    .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
    .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_val(b_rd_val), .count(b_count),
    .almost_full(b_af), .almost_empty(b_ae), .overflow(b_ov), .underflow(b_un));

  sync_fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_c (
    .clk(clk), .reset(reset), .wr_en(c_wr_en), .wr_data(c_wr_data), .wr_ready(c_wr_ready),
    .rd_en(c_rd_en), .rd_data(c_rd_data), .rd_val(c_rd_val), .count(c_count),
    .almost_full(c_af), .almost_empty(c_ae), .overflow(c_ov), .underflow(c_un));

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_wr_en = 0; a_rd_en = 0; b_wr_en = 0; b_rd_en = 0; c_wr_en = 0; c_rd_en = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    a_wr_en = 1; a_rd_en = 1; a_wr_data = 8'hAA;
    b_wr_en = 1; b_rd_en = 1; b_wr_data = 8'hBB;
    c_wr_en = 1; c_rd_en = 1; c_wr_data = 8'hCC;
    tick();
    tick();
    n_cmp++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", a_count); end
    n_cmp++; if (a_wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", a_wr_ready); end
    n_cmp++; if (a_ae !== 1'b1 || a_af !== 1'b0) begin n_fail++; $display("FAIL reset_almost: got ae=%b af=%b want ae=1 af=0", a_ae, a_af); end
    n_cmp++; if (a_ov !== 1'b0 || a_un !== 1'b0) begin n_fail++; $display("FAIL reset_err: got ov=%b un=%b want 0 0", a_ov, a_un); end
    n_cmp++; if (a_rd_val !== 1'b0 || a_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd: got val=%b data=%h want 0 00", a_rd_val, a_rd_data); end
    n_cmp++; if (b_count !== 2'd0 || c_count !== 3'd0 || c_rd_val !== 1'b0) begin n_fail++; $display("FAIL reset_bc: got b_count=%0d c_count=%0d c_val=%b want 0 0 0", b_count, c_count, c_rd_val); end
    reset = 0;
    idle_all();
    tick();
    n_cmp++; if (a_count !== 3'd0 || a_ov !== 1'b0 || a_un !== 1'b0) begin n_fail++; $display("FAIL post_reset: got count=%0d ov=%b un=%b want 0 0 0", a_count, a_ov, a_un); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      a_wr_en = 1; a_wr_data = 8'(11 + i);
      qa.push_back(8'(11 + i));
      tick();
      n_cmp++; if (a_count !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", a_count, i + 1); end
      n_cmp++; if (a_af !== (i + 1 >= 3) || a_ae !== (i + 1 <= 1)) begin n_fail++; $display("FAIL fill_almost: got af=%b ae=%b at count %0d", a_af, a_ae, i + 1); end
    end
    n_cmp++; if (a_wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_wr_ready: got %b want 0", a_wr_ready); end
    a_wr_data = 8'd15;
    tick();
    n_cmp++; if (a_ov !== 1'b1 || a_count !== 3'd4) begin n_fail++; $display("FAIL overflow: got ov=%b count=%0d want 1 4", a_ov, a_count); end
    a_wr_en = 0; a_rd_en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL overflow_pulse: got %b want 0", a_ov); end
      exp_d = (qa.size() != 0) ? qa.pop_front() : 8'hXX;
      n_cmp++; if (a_rd_val !== 1'b1 || a_rd_data !== exp_d) begin n_fail++; $display("FAIL drain_data: got val=%b data=%0d want 1 %0d", a_rd_val, a_rd_data, exp_d); end
    end
    tick();
    n_cmp++; if (a_un !== 1'b1 || a_rd_val !== 1'b0 || a_count !== 3'd0) begin n_fail++; $display("FAIL underflow: got un=%b val=%b count=%0d want 1 0 0", a_un, a_rd_val, a_count); end
    n_cmp++; if (a_rd_data !== 8'd14) begin n_fail++; $display("FAIL rd_data_hold: got %0d want 14", a_rd_data); end
    a_rd_en = 0;
    tick();
    n_cmp++; if (a_un !== 1'b0) begin n_fail++; $display("FAIL underflow_pulse: got %b want 0", a_un); end
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 10; i++) begin
      b_wr_en = 1; b_rd_en = 0; b_wr_data = 8'(i);
      qb.push_back(8'(i));
      tick();
      n_cmp++; if (b_count !== 2'd1) begin n_fail++; $display("FAIL wrap_count_w: got %0d want 1", b_count); end
      b_wr_en = 0; b_rd_en = 1;
      tick();
      exp_d = (qb.size() != 0) ? qb.pop_front() : 8'hXX;
      n_cmp++; if (b_rd_val !== 1'b1 || b_rd_data !== exp_d || b_count !== 2'd0) begin n_fail++; $display("FAIL wrap_data: got val=%b data=%0d count=%0d want 1 %0d 0", b_rd_val, b_rd_data, b_count, exp_d); end
    end
    b_rd_en = 0;
    tick();
  endtask

  task automatic test_simultaneous();
    a_rd_en = 0; a_wr_en = 1;
    for (int i = 0; i < 2; i++) begin
      a_wr_data = 8'(20 + i); qa.push_back(8'(20 + i)); tick();
    end
    a_rd_en = 1; a_wr_data = 8'd22; qa.push_back(8'd22);
    tick();
    exp_d = (qa.size() != 0) ? qa.pop_front() : 8'hXX;
    n_cmp++; if (a_rd_val !== 1'b1 || a_rd_data !== exp_d || a_count !== 3'd2) begin n_fail++; $display("FAIL simul: got val=%b data=%0d count=%0d want 1 %0d 2", a_rd_val, a_rd_data, a_count, exp_d); end
    a_wr_en = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_d = (qa.size() != 0) ? qa.pop_front() : 8'hXX;
      n_cmp++; if (a_rd_val !== 1'b1 || a_rd_data !== exp_d) begin n_fail++; $display("FAIL simul_next: got val=%b data=%0d want 1 %0d", a_rd_val, a_rd_data, exp_d); end
    end
    a_rd_en = 0;
    tick();
  endtask

  task automatic test_empty_simultaneous();
    a_wr_en = 1; a_rd_en = 1; a_wr_data = 8'd30; qa.push_back(8'd30);
    tick();
    n_cmp++; if (a_un !== 1'b1 || a_count !== 3'd1 || a_rd_val !== 1'b0) begin n_fail++; $display("FAIL empty_simul: got un=%b count=%0d val=%b want 1 1 0", a_un, a_count, a_rd_val); end
    a_wr_en = 0;
    tick();
    exp_d = (qa.size() != 0) ? qa.pop_front() : 8'hXX;
    n_cmp++; if (a_rd_val !== 1'b1 || a_rd_data !== exp_d || a_un !== 1'b0) begin n_fail++; $display("FAIL empty_simul_read: got val=%b data=%0d un=%b want 1 %0d 0", a_rd_val, a_rd_data, a_un, exp_d); end
    a_rd_en = 0;
    tick();
  endtask

  task automatic test_full_back_to_back();
    a_wr_en = 1;
    for (int i = 0; i < 4; i++) begin
      a_wr_data = 8'(50 + i); qa.push_back(8'(50 + i)); tick();
    end
    a_rd_en = 1; a_wr_data = 8'd99;
    tick();
    exp_d = (qa.size() != 0) ? qa.pop_front() : 8'hXX;
    n_cmp++; if (a_ov !== 1'b1 || a_count !== 3'd3 || a_rd_data !== exp_d) begin n_fail++; $display("FAIL full_rw: got ov=%b count=%0d data=%0d want 1 3 %0d", a_ov, a_count, a_rd_data, exp_d); end
    a_rd_en = 0; a_wr_data = 8'd54; qa.push_back(8'd54);
    tick();
    n_cmp++; if (a_ov !== 1'b0 || a_count !== 3'd4) begin n_fail++; $display("FAIL refill: got ov=%b count=%0d want 0 4", a_ov, a_count); end
    a_wr_data = 8'd55;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (a_ov !== 1'b1 || a_count !== 3'd4) begin n_fail++; $display("FAIL overflow_repeat: got ov=%b count=%0d want 1 4", a_ov, a_count); end
    end
    a_wr_en = 0; a_rd_en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_d = (qa.size() != 0) ? qa.pop_front() : 8'hXX;
      n_cmp++; if (a_rd_val !== 1'b1 || a_rd_data !== exp_d) begin n_fail++; $display("FAIL full_drain: got val=%b data=%0d want 1 %0d", a_rd_val, a_rd_data, exp_d); end
    end
    a_rd_en = 0;
    tick();
    n_cmp++; if (a_count !== 3'd0 || a_rd_val !== 1'b0 || qa.size() != 0) begin n_fail++; $display("FAIL full_end: got count=%0d val=%b left=%0d want 0 0 0", a_count, a_rd_val, qa.size()); end
  endtask

  task automatic test_fwft();
    c_wr_en = 1; c_wr_data = 8'd40; qc.push_back(8'd40);
    tick();
    exp_d = (qc.size() != 0) ? qc[0] : 8'hXX;
    n_cmp++; if (c_rd_val !== 1'b1 || c_rd_data !== exp_d || c_count !== 3'd1) begin n_fail++; $display("FAIL fwft_first: got val=%b data=%0d count=%0d want 1 %0d 1", c_rd_val, c_rd_data, c_count, exp_d); end
    c_rd_en = 1; c_wr_data = 8'd41; qc.push_back(8'd41);
    if (qc.size() != 0) void'(qc.pop_front());
    tick();
    exp_d = (qc.size() != 0) ? qc[0] : 8'hXX;
    n_cmp++; if (c_rd_val !== 1'b1 || c_rd_data !== exp_d || c_count !== 3'd1) begin n_fail++; $display("FAIL fwft_pop: got val=%b data=%0d count=%0d want 1 %0d 1", c_rd_val, c_rd_data, c_count, exp_d); end
    c_rd_en = 0;
    for (int i = 0; i < 2; i++) begin
      c_wr_data = 8'(42 + i); qc.push_back(8'(42 + i)); tick();
    end
    n_cmp++; if (c_count !== 3'd3 || c_rd_data !== qc[0]) begin n_fail++; $display("FAIL fwft_fill: got count=%0d data=%0d want 3 %0d", c_count, c_rd_data, qc[0]); end
    c_wr_en = 0;
    reset = 1; qc.delete();
    tick();
    n_cmp++; if (c_rd_val !== 1'b0 || c_count !== 3'd0) begin n_fail++; $display("FAIL fwft_reset: got val=%b count=%0d want 0 0", c_rd_val, c_count); end
    reset = 0;
    tick();
  endtask

  initial begin
    reset = 1;
    a_wr_data = '0; b_wr_data = '0; c_wr_data = '0;
    idle_all();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_empty_simultaneous();
    test_full_back_to_back();
    test_fwft();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
